// File: rtl/sorter_pkg.sv
// Shared constants and FSM encoding for the UART counting-sort engine.
package sorter_pkg;

  localparam int VALUE_W = 10;
  localparam int BINS    = 1024;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = 16;
  localparam logic [15:0] PRESCALE_DEF = 16'd13;

  typedef enum logic [3:0] {
    S_CLEAR,
    S_RX_LEN_LO,
    S_RX_LEN_HI,
    S_RX_VAL_LO,
    S_RX_VAL_HI,
    S_INC_RD,
    S_INC_WR,
    S_TX_LEN_LO,
    S_TX_LEN_HI,
    S_SCAN_RD,
    S_SCAN_CHK,
    S_TX_VAL_LO,
    S_TX_VAL_HI,
    S_DEC
  } state_t;

endpackage

// File: rtl/sort_bin_ram.sv
// 1024 x 16 histogram RAM, single port, registered write-first read so a
// re-read right after a write already returns the updated count.
module sort_bin_ram
  import sorter_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [VALUE_W-1:0] i_addr,
  input  logic [CNT_W-1:0]   i_wdata,
  output logic [CNT_W-1:0]   o_rdata
);

  logic [CNT_W-1:0] r_mem [BINS];
  logic [CNT_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, bit period = 8*prescale clocks, AXI-stream byte output.
// An unread byte is overwritten if a new one completes before it is taken.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] prescale,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  logic [1:0]  r_sync;
  logic        r_busy;
  logic [3:0]  r_bits;
  logic [18:0] r_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic [18:0] w_bit;
  logic [18:0] w_half;
  logic        w_rx;

  assign w_bit  = {prescale, 3'b000};
  assign w_half = {1'b0, prescale, 2'b00};
  assign w_rx   = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_busy  <= 1'b0;
      r_bits  <= 4'd0;
      r_cnt   <= 19'd0;
      r_shift <= 8'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      if (r_valid && m_axis_tready) r_valid <= 1'b0;
      if (!r_busy) begin
        if (!w_rx) begin
          r_busy <= 1'b1;
          r_bits <= 4'd0;
          r_cnt  <= w_half - 19'd1;
        end
      end else if (r_cnt != 19'd0) begin
        r_cnt <= r_cnt - 19'd1;
      end else begin
        r_cnt <= w_bit - 19'd1;
        if (r_bits == 4'd0) begin
          // Start bit re-checked at mid-bit to reject glitches.
          if (w_rx) r_busy <= 1'b0;
          else      r_bits <= 4'd1;
        end else if (r_bits <= 4'd8) begin
          r_shift <= {w_rx, r_shift[7:1]};
          r_bits  <= r_bits + 4'd1;
        end else begin
          r_busy <= 1'b0;
          if (w_rx) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign m_axis_tdata  = r_data;
  assign m_axis_tvalid = r_valid;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, bit period = 8*prescale clocks, AXI-stream byte input.
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        txd,
  input  logic [15:0] prescale
);

  logic        r_busy;
  logic        r_txd;
  logic [8:0]  r_shift;
  logic [3:0]  r_bits;
  logic [18:0] r_cnt;
  logic [18:0] w_bit;

  assign w_bit = {prescale, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
      r_shift <= 9'd0;
      r_bits  <= 4'd0;
      r_cnt   <= 19'd0;
    end else if (!r_busy) begin
      if (s_axis_tvalid) begin
        r_busy  <= 1'b1;
        r_txd   <= 1'b0;
        r_shift <= {1'b1, s_axis_tdata};
        r_bits  <= 4'd9;
        r_cnt   <= w_bit - 19'd1;
      end
    end else if (r_cnt != 19'd0) begin
      r_cnt <= r_cnt - 19'd1;
    end else if (r_bits != 4'd0) begin
      r_txd   <= r_shift[0];
      r_shift <= {1'b1, r_shift[8:1]};
      r_bits  <= r_bits - 4'd1;
      r_cnt   <= w_bit - 19'd1;
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign s_axis_tready = !r_busy;
  assign txd           = r_txd;

endmodule

// File: rtl/uart_sorter_top.sv
// UART counting-sort engine: receive N and N 10-bit values, histogram them,
// then reply with N and the values in ascending order (bins drain to zero).
module uart_sorter_top
  import sorter_pkg::*;
#(
  parameter logic [15:0] PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd
);

  state_t             r_state;
  logic [VALUE_W-1:0] r_clr_addr;
  logic [LEN_W-1:0]   r_len;
  logic [7:0]         r_val_lo;
  logic [VALUE_W-1:0] r_val;
  logic [LEN_W-1:0]   r_rcvd;
  logic [VALUE_W-1:0] r_addr;
  logic [LEN_W-1:0]   r_emit;

  logic [7:0]         w_rx_data;
  logic               w_rx_valid;
  logic               w_rx_ready;
  logic [7:0]         w_tx_data;
  logic               w_tx_valid;
  logic               w_tx_ready;
  logic               w_ram_we;
  logic [VALUE_W-1:0] w_ram_addr;
  logic [CNT_W-1:0]   w_ram_wdata;
  logic [CNT_W-1:0]   w_ram_rdata;
  logic               w_rx_fire;
  logic               w_tx_fire;

  uart_rx u_rx (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (PRESCALE),
    .m_axis_tdata  (w_rx_data),
    .m_axis_tvalid (w_rx_valid),
    .m_axis_tready (w_rx_ready)
  );

  uart_tx u_tx (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (w_tx_data),
    .s_axis_tvalid (w_tx_valid),
    .s_axis_tready (w_tx_ready),
    .txd           (txd),
    .prescale      (PRESCALE)
  );

  sort_bin_ram u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_rx_fire = w_rx_valid && w_rx_ready;
  assign w_tx_fire = w_tx_valid && w_tx_ready;

  always_comb begin
    w_rx_ready  = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'd0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_addr;
    w_ram_wdata = '0;
    case (r_state)
      S_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
      end
      S_RX_LEN_LO, S_RX_LEN_HI, S_RX_VAL_LO, S_RX_VAL_HI: w_rx_ready = 1'b1;
      S_INC_RD: w_ram_addr = r_val;
      S_INC_WR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_val;
        w_ram_wdata = w_ram_rdata + 16'd1;
      end
      S_TX_LEN_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_len[7:0];
      end
      S_TX_LEN_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_len[15:8];
      end
      S_TX_VAL_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_addr[7:0];
      end
      S_TX_VAL_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = {6'd0, r_addr[9:8]};
      end
      // Read data still holds bin[r_addr]: no writes since the SCAN_CHK read.
      S_DEC: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = w_ram_rdata - 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_len      <= '0;
      r_val_lo   <= 8'd0;
      r_val      <= '0;
      r_rcvd     <= '0;
      r_addr     <= '0;
      r_emit     <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) r_state <= S_RX_LEN_LO;
        end
        S_RX_LEN_LO: if (w_rx_fire) begin
          r_len[7:0] <= w_rx_data;
          r_state    <= S_RX_LEN_HI;
        end
        S_RX_LEN_HI: if (w_rx_fire) begin
          r_len[15:8] <= w_rx_data;
          r_rcvd      <= '0;
          r_state     <= ({w_rx_data, r_len[7:0]} == 16'd0) ? S_TX_LEN_LO : S_RX_VAL_LO;
        end
        S_RX_VAL_LO: if (w_rx_fire) begin
          r_val_lo <= w_rx_data;
          r_state  <= S_RX_VAL_HI;
        end
        S_RX_VAL_HI: if (w_rx_fire) begin
          r_val   <= {w_rx_data[1:0], r_val_lo};
          r_state <= S_INC_RD;
        end
        S_INC_RD: r_state <= S_INC_WR;
        S_INC_WR: begin
          r_rcvd  <= r_rcvd + 16'd1;
          r_state <= (r_rcvd + 16'd1 == r_len) ? S_TX_LEN_LO : S_RX_VAL_LO;
        end
        S_TX_LEN_LO: if (w_tx_fire) r_state <= S_TX_LEN_HI;
        S_TX_LEN_HI: if (w_tx_fire) begin
          r_addr  <= '0;
          r_emit  <= '0;
          r_state <= (r_len == 16'd0) ? S_RX_LEN_LO : S_SCAN_RD;
        end
        S_SCAN_RD: r_state <= S_SCAN_CHK;
        S_SCAN_CHK: begin
          if (w_ram_rdata == '0) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_SCAN_RD;
          end else begin
            r_state <= S_TX_VAL_LO;
          end
        end
        S_TX_VAL_LO: if (w_tx_fire) r_state <= S_TX_VAL_HI;
        S_TX_VAL_HI: if (w_tx_fire) r_state <= S_DEC;
        S_DEC: begin
          r_emit  <= r_emit + 16'd1;
          r_state <= (r_emit + 16'd1 == r_len) ? S_RX_LEN_LO : S_SCAN_CHK;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sorter_top.sv
// Drives host frames over rxd, decodes txd, and checks the reply against a
// sorted copy of the values sent.
module tb_uart_sorter_top;

  localparam logic [15:0] PRESC = 16'd2;
  localparam int BIT = 8 * PRESC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  logic       stop_q[$];
  int         frame_q[$];

  uart_sorter_top #(.PRESCALE(PRESC)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .txd (txd)
  );

  always #5 clk = ~clk;

  // Line decoder for txd.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        stop_q.push_back(txd);
        rx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int junk_idx);
    int         n;
    int         v;
    int         srt[$];
    logic [7:0] exp_q[$];
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] got;
    logic       st;
    int         waited;
    int         budget;

    n = frame_q.size();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (frame_q[i]) begin
      v  = frame_q[i];
      lo = v[7:0];
      hi = {6'd0, v[9:8]};
      if (i == junk_idx) hi[7:2] = 6'd1;
      send_byte(lo);
      send_byte(hi);
    end

    srt = frame_q;
    srt.sort();
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    foreach (srt[i]) begin
      v = srt[i];
      exp_q.push_back(v[7:0]);
      exp_q.push_back({6'd0, v[9:8]});
    end

    budget = exp_q.size() * 10 * BIT + 4000;
    waited = 0;
    while (rx_q.size() < exp_q.size() && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("%s reply_count", name), rx_q.size(), exp_q.size());

    foreach (exp_q[k]) begin
      if (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        st  = stop_q.pop_front();
      end else begin
        got = 'x;
        st  = 1'bx;
      end
      chk($sformatf("%s byte%0d", name, k), got, exp_q[k]);
      chk($sformatf("%s stop%0d", name, k), st, 1'b1);
    end

    repeat (40 * BIT) @(negedge clk);
    chk($sformatf("%s no_extra", name), rx_q.size(), 0);
    $display("frame %s: N=%0d, %0d reply bytes checked", name, n, exp_q.size());
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset txd", txd, 1'b1);
    repeat (500) @(negedge clk);
    chk("clear txd idle", txd, 1'b1);
    repeat (600) @(negedge clk);

    frame_q = '{5, 4, 1};
    run_frame("basic", -1);
    frame_q = '{5, 2, 5, 1, 5, 2};
    run_frame("dups", -1);
    frame_q = '{100, 100, 100};
    run_frame("same", -1);
    frame_q = '{1023, 0, 511, 256};
    run_frame("extremes", -1);
    frame_q.delete();
    run_frame("empty", -1);
    frame_q = '{42};
    run_frame("single", -1);
    frame_q.delete();
    repeat (20) frame_q.push_back(int'($urandom_range(0, 1023)));
    run_frame("random", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
